wrr_stream_arbiter: RTL and testbench
=====================================

WRR_STREAM_ARBITER -- requirements
Module: wrr_stream_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width per channel.
REQ-003 SHALL have parameter WEIGHT_BITS, default 4: width of each per-channel burst quota.
REQ-004 SHALL have derived constant CH_BITS = clog2(CHANNELS), minimum 1.
REQ-005 BUS_CLK  in  1  single clock; all logic is clocked by its rising edge.
REQ-006 BUS_RST  in  1  reset; synchronous, active-high.
REQ-007 WRITE_REQ  in  CHANNELS  per-channel source FIFO not empty; DATA_IN for that channel is valid while high.
REQ-008 HOLD_REQ  in  CHANNELS  per-channel preempt request; keeps the grant on that channel.
REQ-009 DATA_IN  in  CHANNELS*DATA_WIDTH  concatenated source words; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 WEIGHT  in  CHANNELS*WEIGHT_BITS  per-channel burst quota; quasi-static, sampled every cycle.
REQ-011 READ_GRANT  out  CHANNELS  one-cycle pop strobe to source FIFO i; at most one bit high.
REQ-012 WRITE_OUT  out  1  DATA_OUT holds a valid word.
REQ-013 READY_OUT  in  1  sink accepts a word this cycle.
REQ-014 DATA_OUT  out  DATA_WIDTH  registered output word.
REQ-015 CHAN_OUT  out  CH_BITS  registered source-channel index of DATA_OUT.

Function
REQ-016 SHALL implement a two-state FSM: SELECT and GRANT, with registers cur (CH_BITS) and cnt (WEIGHT_BITS).
REQ-017 Effective quota SHALL be WEIGHT[cur], with 0 treated as 1.
REQ-018 In SELECT, if any WRITE_REQ bit is high, SHALL set cur to the first requesting index searching cur+1, cur+2, ... mod CHANNELS (cur itself last), clear cnt, go to GRANT; otherwise stay in SELECT.
REQ-019 Output transfer SHALL occur in a cycle when WRITE_OUT && READY_OUT.
REQ-020 load SHALL be defined as state==GRANT && WRITE_REQ[cur] && (!WRITE_OUT || READY_OUT).
REQ-021 On load: READ_GRANT[cur] high that cycle, combinationally; DATA_OUT <= DATA_IN[cur]; CHAN_OUT <= cur; WRITE_OUT <= 1; cnt <= cnt+1 (saturating).
REQ-022 On transfer without load: WRITE_OUT <= 0; DATA_OUT and CHAN_OUT hold.
REQ-023 Latency: word popped with READ_GRANT in cycle n SHALL appear on DATA_OUT/WRITE_OUT in cycle n+1.
REQ-024 GRANT -> SELECT SHALL occur when HOLD_REQ[cur]==0 and either (load and cnt+1 == effective quota) or (!WRITE_REQ[cur]).
REQ-025 While HOLD_REQ[cur]==1, SHALL remain in GRANT regardless of quota or empty source; cnt saturates at all-ones.
REQ-026 Sink backpressure (WRITE_OUT && !READY_OUT) SHALL stall without loss, without READ_GRANT, and without changing state or cnt.
REQ-027 Throughput within a burst SHALL be one word per cycle with READY_OUT held high; each channel switch costs exactly one SELECT cycle.
REQ-028 HOLD_REQ on non-granted channels SHALL be ignored until that channel is selected.
REQ-029 A single requester SHALL be reselected after its quota with one bubble cycle (wrap to itself).

Reset
REQ-030 On BUS_RST: state=SELECT, cur=CHANNELS-1 (first search starts at 0), cnt=0, WRITE_OUT=0, DATA_OUT=0, CHAN_OUT=0, READ_GRANT=0.
REQ-031 Reset mid-burst SHALL discard the registered word; no READ_GRANT in the reset cycle or the cycle after.

Structure
REQ-032 CH_BITS computation and FSM state encoding SHALL live in a shared package used by top level and bench.
REQ-033 Round-robin next-requester search SHALL be one sub-module, rr_next_sel (inputs req vector, cur; output next index, any).

Verification
REQ-034 Reset, all WRITE_REQ=4'b1111, WEIGHT all 1, READY_OUT=1 -> CHAN_OUT sequence 0,1,2,3,0 with one bubble between words.
REQ-035 WEIGHT={1,1,1,3} (ch0=3), all requesting -> ch0 gets 3 consecutive words, then ch1, ch2, ch3 one each.
REQ-036 ch2 granted, HOLD_REQ[2]=1, WRITE_REQ[2] toggles 1,0,1 -> grant stays on ch2; only ch2 words out until HOLD_REQ drops.
REQ-037 READY_OUT=0 for 5 cycles with WRITE_OUT=1 -> DATA_OUT stable, READ_GRANT=0, no word lost or duplicated (scoreboard).
REQ-038 Only WRITE_REQ[1]=1, WEIGHT[1]=0 -> ch1 word every 2 cycles (quota 1, SELECT bubble).
REQ-039 BUS_RST asserted mid-burst on ch3 -> next cycle WRITE_OUT=0, cur restarts search at 0.

Source files
------------

// File: rtl/wrr_stream_arbiter_pkg.sv
// Shared types for the weighted round-robin stream arbiter: FSM state encoding
// and the channel-index width helper used by the RTL and its bench.
package wrr_stream_arbiter_pkg;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_GRANT  = 1'b1
    } arb_state_t;

    // Index width for n channels, never below one bit.
    function automatic int ch_bits_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrr_stream_arbiter_rr_next_sel.sv
// Round-robin search: first requester after i_cur (wrapping, i_cur itself last).
// Purely combinational; no handshake of its own.
module rr_next_sel
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = ch_bits_f(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [CH_BITS-1:0]  i_cur,
    output logic [CH_BITS-1:0]  o_next,
    output logic                o_any
);

    logic               w_found_hi;
    logic [CH_BITS-1:0] w_next_hi;
    logic [CH_BITS-1:0] w_next_lo;

    // Descending scan: the last hit is the lowest index, both above i_cur and overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_next_hi  = '0;
        w_next_lo  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_next_lo = CH_BITS'(i);
                if (i > int'(i_cur)) begin
                    w_next_hi  = CH_BITS'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign o_next = w_found_hi ? w_next_hi : w_next_lo;
    assign o_any  = |i_req;

endmodule

// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin arbiter draining per-channel FIFOs into one registered stream.
// Pop-to-output latency one cycle; sink stall freezes grants, state and burst count.
module wrr_stream_arbiter
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  DATA_WIDTH  = 32,
    parameter int  WEIGHT_BITS = 4,
    localparam int CH_BITS     = ch_bits_f(CHANNELS)
) (
    input  logic                            BUS_CLK,
    input  logic                            BUS_RST,
    input  logic [CHANNELS-1:0]             WRITE_REQ,
    input  logic [CHANNELS-1:0]             HOLD_REQ,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  DATA_IN,
    input  logic [CHANNELS*WEIGHT_BITS-1:0] WEIGHT,
    output logic [CHANNELS-1:0]             READ_GRANT,
    output logic                            WRITE_OUT,
    input  logic                            READY_OUT,
    output logic [DATA_WIDTH-1:0]           DATA_OUT,
    output logic [CH_BITS-1:0]              CHAN_OUT
);

    arb_state_t             r_state;
    logic [CH_BITS-1:0]     r_cur;
    logic [WEIGHT_BITS-1:0] r_cnt;
    logic                   r_wout;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic [CH_BITS-1:0]     r_chan;

    logic [CH_BITS-1:0]     w_next;
    logic                   w_any;
    logic                   w_req_cur;
    logic                   w_hold_cur;
    logic [WEIGHT_BITS-1:0] w_weight;
    logic [WEIGHT_BITS-1:0] w_quota;
    logic [WEIGHT_BITS:0]   w_cnt_inc;
    logic                   w_quota_hit;
    logic                   w_load;
    logic                   w_xfer;

    rr_next_sel #(
        .CHANNELS (CHANNELS),
        .CH_BITS  (CH_BITS)
    ) u_rr_next_sel (
        .i_req  (WRITE_REQ),
        .i_cur  (r_cur),
        .o_next (w_next),
        .o_any  (w_any)
    );

    assign w_req_cur   = WRITE_REQ[r_cur];
    assign w_hold_cur  = HOLD_REQ[r_cur];
    assign w_weight    = WEIGHT[int'(r_cur)*WEIGHT_BITS +: WEIGHT_BITS];
    assign w_quota     = (w_weight == '0) ? WEIGHT_BITS'(1) : w_weight;
    // One bit wider so an all-ones count never wraps into a false quota match.
    assign w_cnt_inc   = {1'b0, r_cnt} + {{WEIGHT_BITS{1'b0}}, 1'b1};
    assign w_quota_hit = (w_cnt_inc == {1'b0, w_quota});
    assign w_load      = (r_state == ST_GRANT) && w_req_cur && (!r_wout || READY_OUT) && !BUS_RST;
    assign w_xfer      = r_wout && READY_OUT;

    always_comb begin
        READ_GRANT = '0;
        if (w_load) READ_GRANT[r_cur] = 1'b1;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_state <= ST_SELECT;
            r_cur   <= CH_BITS'(CHANNELS - 1);
            r_cnt   <= '0;
            r_wout  <= 1'b0;
            r_dout  <= '0;
            r_chan  <= '0;
        end else begin
            if (w_load) begin
                r_dout <= DATA_IN[int'(r_cur)*DATA_WIDTH +: DATA_WIDTH];
                r_chan <= r_cur;
                r_wout <= 1'b1;
            end else if (w_xfer) begin
                r_wout <= 1'b0;
            end

            case (r_state)
                ST_SELECT: begin
                    if (w_any) begin
                        r_cur   <= w_next;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_load && !(&r_cnt)) r_cnt <= w_cnt_inc[WEIGHT_BITS-1:0];
                    // A held channel keeps the grant through quota expiry and empty source.
                    if (!w_hold_cur && ((w_load && w_quota_hit) || !w_req_cur))
                        r_state <= ST_SELECT;
                end
                default: r_state <= ST_SELECT;
            endcase
        end
    end

    assign WRITE_OUT = r_wout;
    assign DATA_OUT  = r_dout;
    assign CHAN_OUT  = r_chan;

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Scoreboard bench for wrr_stream_arbiter: finite per-channel sources feed the DUT,
// directed tests push hand-computed words, a negedge monitor pops and compares.
module tb_wrr_stream_arbiter;
    import wrr_stream_arbiter_pkg::*;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int WB = 4;
    localparam int CB = ch_bits_f(CH);

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    write_req;
    logic [CH-1:0]    hold_req;
    logic [CH*DW-1:0] data_in;
    logic [CH*WB-1:0] weight;
    logic [CH-1:0]    read_grant;
    logic             write_out;
    logic             ready_out;
    logic [DW-1:0]    data_out;
    logic [CB-1:0]    chan_out;

    always #5 clk = ~clk;

    wrr_stream_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .WEIGHT_BITS(WB)) dut (
        .BUS_CLK    (clk),
        .BUS_RST    (rst),
        .WRITE_REQ  (write_req),
        .HOLD_REQ   (hold_req),
        .DATA_IN    (data_in),
        .WEIGHT     (weight),
        .READ_GRANT (read_grant),
        .WRITE_OUT  (write_out),
        .READY_OUT  (ready_out),
        .DATA_OUT   (data_out),
        .CHAN_OUT   (chan_out)
    );

    // Source FIFO models: channel i holds avail[i] words, pop_cnt[i] already read.
    int         avail   [CH];
    int         pop_cnt [CH];
    logic       src_clr;
    logic [7:0] tid;

    always_comb begin
        write_req = '0;
        data_in   = '0;
        for (int i = 0; i < CH; i++) begin
            write_req[i]         = pop_cnt[i] < avail[i];
            data_in[i*DW +: DW]  = {8'(i + 1), tid, 16'(pop_cnt[i])};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (src_clr)            pop_cnt[i] <= 0;
            else if (read_grant[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [CB-1:0] ch;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   xc[$];
    int   gc[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [DW-1:0] dat_of(input int ch, input int idx);
        return {8'(ch + 1), tid, 16'(idx)};
    endfunction

    task automatic expect_w(input int ch, input int idx);
        sb_q.push_back({CB'(ch), dat_of(ch, idx)});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted output word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(read_grant)) begin
                errors++;
                $display("FAIL grant_onehot: got %b expected at most one bit", read_grant);
            end
            if (read_grant != '0) gc.push_back(cyc);
            if (write_out && ready_out) begin
                exp_t e;
                xc.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL word: got ch=%0d dat=%h expected no word", chan_out, data_out);
                end else begin
                    e = sb_q.pop_front();
                    if (chan_out !== e.ch || data_out !== e.dat) begin
                        errors++;
                        $display("FAIL word: got ch=%0d dat=%h expected ch=%0d dat=%h",
                                 chan_out, data_out, e.ch, e.dat);
                    end
                end
            end
        end
    end

    task automatic start_test(input logic [7:0] id, input logic [CH*WB-1:0] w);
        rst       = 1'b1;
        src_clr   = 1'b1;
        tid       = id;
        weight    = w;
        hold_req  = '0;
        ready_out = 1'b1;
        for (int i = 0; i < CH; i++) avail[i] = 0;
        tick();
        tick();
        sb_q.delete();
        xc.delete();
        gc.delete();
        src_clr = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || write_out) && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk({name, "_drain_left"}, sb_q.size(), 0);
    endtask

    task automatic chk_gaps(input string name, input int n_words, input int n_fast, input int fast_gap);
        chk({name, "_count"}, xc.size(), n_words);
        if (xc.size() == n_words) begin
            for (int k = 1; k < n_words; k++)
                chk({name, "_gap"}, xc[k] - xc[k-1], (k <= n_fast) ? fast_gap : 2);
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_clr   = 1'b1;
        hold_req  = '0;
        ready_out = 1'b1;
        weight    = '0;
        tid       = '0;
        for (int i = 0; i < CH; i++) avail[i] = 0;
        repeat (3) tick();
        chk("rst_write_out", write_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_chan_out", chan_out, 0);
        chk("rst_read_grant", read_grant, 0);

        // All four requesting with quota 1: 0,1,2,3,0 with a bubble between words.
        start_test(8'h01, 16'h1111);
        expect_w(0, 0); expect_w(1, 0); expect_w(2, 0); expect_w(3, 0); expect_w(0, 1);
        avail[0] = 2; avail[1] = 1; avail[2] = 1; avail[3] = 1;
        wait_drain("rr");
        chk_gaps("rr", 5, 0, 2);
        chk("rr_grant_count", gc.size(), 5);
        if (gc.size() == 5 && xc.size() == 5)
            for (int k = 0; k < 5; k++) chk("rr_latency", xc[k] - gc[k], 1);

        // ch0 quota 3: three back-to-back words before moving on.
        start_test(8'h02, 16'h1113);
        expect_w(0, 0); expect_w(0, 1); expect_w(0, 2);
        expect_w(1, 0); expect_w(2, 0); expect_w(3, 0); expect_w(0, 3);
        avail[0] = 4; avail[1] = 1; avail[2] = 1; avail[3] = 1;
        wait_drain("wgt");
        chk_gaps("wgt", 7, 2, 1);

        // ch2 held while its source runs dry and refills; others wait.
        start_test(8'h03, 16'h1111);
        hold_req = 4'b0100;
        avail[2] = 1;
        expect_w(2, 0); expect_w(2, 1); expect_w(2, 2);
        expect_w(3, 0); expect_w(0, 0); expect_w(3, 1);
        repeat (4) tick();
        avail[0] = 1; avail[3] = 2;
        repeat (4) tick();
        chk("hold_no_other_pop", pop_cnt[0] + pop_cnt[3], 0);
        avail[2] = 2;
        repeat (4) tick();
        avail[2] = 3;
        repeat (4) tick();
        chk("hold_chan", chan_out, 2);
        chk("hold_pops_ch2", pop_cnt[2], 3);
        chk("hold_no_other_pop2", pop_cnt[0] + pop_cnt[3], 0);
        hold_req = '0;
        wait_drain("hold");

        // Sink stall for five cycles with a word pending.
        start_test(8'h04, 16'h0040);
        avail[1] = 4;
        for (int k = 0; k < 4; k++) expect_w(1, k);
        begin
            int n;
            n = 0;
            while (!write_out && n < 50) begin
                tick();
                n++;
            end
            chk("stall_wait", n < 50, 1);
        end
        ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", data_out, dat_of(1, 0));
            chk("stall_grant", read_grant, 0);
            chk("stall_wout", write_out, 1);
        end
        chk("stall_pops", pop_cnt[1], 1);
        ready_out = 1'b1;
        wait_drain("stall");
        chk("stall_count", xc.size(), 4);

        // Lone requester with weight 0 behaves as quota 1.
        start_test(8'h05, 16'h0000);
        avail[1] = 3;
        expect_w(1, 0); expect_w(1, 1); expect_w(1, 2);
        wait_drain("solo");
        chk_gaps("solo", 3, 0, 2);

        // Reset in the middle of a ch3 burst.
        start_test(8'h06, 16'h4000);
        avail[3] = 4;
        for (int k = 0; k < 4; k++) expect_w(3, k);
        begin
            int n;
            n = 0;
            while (xc.size() < 2 && n < 50) begin
                tick();
                n++;
            end
            chk("mid_rst_wait", n < 50, 1);
        end
        rst = 1'b1;
        #1;
        chk("rst_cycle_grant", read_grant, 0);
        tick();
        chk("post_rst_wout", write_out, 0);
        chk("post_rst_grant", read_grant, 0);
        chk("post_rst_chan", chan_out, 0);
        sb_q.delete();
        avail[3] = pop_cnt[3];
        avail[0] = 1;
        avail[1] = 1;
        expect_w(0, 0); expect_w(1, 0);
        rst = 1'b0;
        #1;
        chk("after_rst_grant", read_grant, 0);
        wait_drain("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
